// File: rtl/ser_pkg.sv
// ser_pkg - shared definitions for the serial sequencer slice.
//   W_DEF        default data word width
//   ser_state_e  sequencer state encoding
package ser_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ser_state_e;

endpackage

// File: rtl/ser_seq_ctrl_shr_ld.sv
// shr_ld - W-bit shift-right register with parallel load.
//   clk    system clock
//   rst_b  async active-low reset, clears the register
//   sh_i   shift right by one, zero fill at the MSB
//   ld_i   parallel load of d_i (lower priority than sh_i)
//   d_i    parallel load word
//   q_o    register contents
module shr_ld
  import ser_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         sh_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] shr_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      shr_q <= '0;
    end else if (sh_i) begin
      shr_q <= {1'b0, shr_q[W-1:1]};
    end else if (ld_i) begin
      shr_q <= d_i;
    end
  end

  assign q_o = shr_q;

endmodule

// File: rtl/ser_seq_ctrl.sv
// ser_seq_ctrl - serializes a captured word LSB first, emitting N bits.
//   clk      system clock
//   rst_b    async active-low reset
//   start    transaction request, sampled only while rdy=1
//   abort    synchronous cancel, has priority over start
//   data_in  word to serialize, captured with start
//   cnt_in   bit count, 0 or > W means W
//   rdy      idle and able to accept start
//   busy     transaction in progress
//   bit_out  current serial bit, qualified by bit_vld
//   bit_vld  one per emitted bit
//   done     one-cycle pulse on normal completion
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for start; word and count captured here
// ST_LOAD  | captured word copied into the shifter
// ST_SHIFT | one bit per cycle, remaining-bit counter falls
// ST_DONE  | completion pulse, back to idle
module ser_seq_ctrl
  import ser_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = $clog2(W+1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  data_in,
  input  logic [CW-1:0] cnt_in,
  output logic          rdy,
  output logic          busy,
  output logic          bit_out,
  output logic          bit_vld,
  output logic          done
);

  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  ser_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] eff_cnt;
  logic          sh_en;
  logic          ld_en;
  logic [W-1:0]  shr_word;

  // Zero means a full word; anything larger than the word is clamped.
  always_comb begin
    eff_cnt = cnt_in;
    if (cnt_in == '0 || cnt_in > CNT_FULL) begin
      eff_cnt = CNT_FULL;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ld_en   = 1'b0;
    sh_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_LOAD;
          data_d  = data_in;
          cnt_d   = eff_cnt;
        end
      end
      ST_LOAD: begin
        ld_en = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sh_en = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          // <= rather than == so a corrupted zero count cannot wrap and run on.
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  shr_ld #(
    .W (W)
  ) u_shr_ld (
    .clk   (clk),
    .rst_b (rst_b),
    .sh_i  (sh_en),
    .ld_i  (ld_en),
    .d_i   (data_q),
    .q_o   (shr_word)
  );

  assign rdy     = (state_q == ST_IDLE);
  assign busy    = (state_q != ST_IDLE);
  assign bit_vld = (state_q == ST_SHIFT);
  assign bit_out = shr_word[0];
  // A cancelled transaction must not report completion, even from DONE.
  assign done    = (state_q == ST_DONE) && !abort;

endmodule
